mtr_drv_pwm: RTL
================

Name: mtr_drv_pwm

Overview:
Consumes the signed 12-bit lft_spd/rght_spd commands produced by balance control and drives the two H-bridges. Each motor gets complementary high-side/low-side PWM at 11-bit resolution with non-overlap dead time. The block also provides over-current blanking and a sticky shutdown. It sits between balance control and the motor driver pins at the chip top level.

Parameters:
DEAD_TIME, 32, clocks both bridge outputs are held low after every raw PWM transition (range 2..255).
BLANK_CNT, 128, PWM count below which ovr_i is ignored (switching-transient blanking).
OVR_PERIODS, 4, consecutive PWM periods with qualified over-current that trigger shutdown (range 1..15).

Ports:
clk  in  1  50MHz system clock
rst_n  in  1  reset, asynchronous, active-low
lft_spd  in  12  signed left speed command
rght_spd  in  12  signed right speed command
drv_en  in  1  drive enable; when low, all bridge outputs are low
ovr_i  in  1  over-current comparator from bridge, synchronous to clk
clr_shtdwn  in  1  one-clock pulse that clears the shutdown state
lft_hi  out  1  left high-side gate
lft_lo  out  1  left low-side gate
rght_hi  out  1  right high-side gate
rght_lo  out  1  right low-side gate
period_strt  out  1  one-clock pulse when cnt==0
ovr_shtdwn  out  1  sticky over-current shutdown flag

Behaviour:
- Reset values:
  - cnt=0.
  - Duty shadows=0x400, which is zero speed at 50%.
  - All gate outputs 0; period_strt=0; ovr_shtdwn=0; over-current period counter=0.
- cnt: 11-bit free-running counter, +1 per clk, wraps 0x7FF->0x000. One period is 2048 clocks.
- Speed conversion:
  - Saturate the signed speed to [-1024, +1023] (e.g. 0x600 -> 0x3FF, 0x900 -> -1024).
  - duty = sat + 0x400, giving unsigned 11 bits in 0..2047.
- Duty latching and latency:
  - Both duty shadows latch only on the cycle cnt==0x7FF.
  - Command changes mid-period have no effect until the next period, which starts at cnt==0.
  - Worst-case latency from a speed change to the output is one full period plus DEAD_TIME.
- Raw PWM: raw = (cnt < duty), combinational per motor.
  - duty=0 gives raw always 0.
  - duty=2047 gives raw low only at cnt=0x7FF.
- Non-overlap, per motor:
  - Track the registered previous raw value.
  - On any raw transition: both hi and lo go low at that clock edge and the dead counter clears.
  - After exactly DEAD_TIME low clocks, hi=raw and lo=~raw.
  - hi and lo must never be 1 simultaneously in any cycle, including around reset and drv_en edges.
  - If raw toggles again before the dead time expires, the dead counter restarts and both outputs stay low.
- Gating:
  - drv_en=0 or ovr_shtdwn=1 forces all four gates low; cnt and the duty shadows keep running.
  - When gating is released, outputs resume only after a fresh DEAD_TIME low interval (the dead counters are held clear while gated).
- period_strt: registered, asserted for the cycle cnt==0.
- Over-current qualification:
  - qual = ovr_i & (lft_hi | rght_hi) & (cnt >= BLANK_CNT).
  - A per-period flag sets on any qual cycle.
  - At cnt==0x7FF: if the flag is set (including this cycle's qual), the consecutive counter increments; otherwise it clears to 0. The flag then clears.
- Shutdown:
  - When the consecutive counter reaches OVR_PERIODS, ovr_shtdwn sets on the next clock and stays set.
  - clr_shtdwn clears ovr_shtdwn, the consecutive counter and the flag.
  - clr_shtdwn coinciding with a set condition: clear wins.
- Reset mid-period returns everything to the reset values immediately (asynchronous). Gates drop without dead time.

Decomposition:
- Package mtr_drv_pkg holds:
  - localparams PWM_W=11, DUTY_MID=11'h400, SPD_MAX=12'sh3FF, SPD_MIN=12'shC00.
  - typedef duty_t (logic [10:0]).
  - function spd2duty (saturate and offset).
- Sub-module nonoverlap (inputs raw, gate_en; outputs hi, lo; parameter DEAD_TIME), instantiated once per motor.
- The top level owns the counter, duty shadows and over-current logic.

Test Plan:
1. Reset, drv_en=1, lft_spd=0 -> duty 0x400. Within one period lft_hi high for cnt DEAD_TIME..1023 (992 clocks), lft_lo high for cnt 1024+DEAD_TIME..2047 plus 0..DEAD_TIME-1 low; the hi&lo overlap assertion never fires.
2. lft_spd=+0x600 and rght_spd=-0x700 applied at cnt=0x100 -> no change until the next cnt==0. Then left duty=0x7FF (lft_lo never asserts, because the raw low interval of 1 clock is shorter than the dead time) and right duty=0 (rght_hi never asserts).
3. drv_en toggled 1->0->1 at cnt=0x050 -> gates low immediately. After re-enable, gates low for exactly 32 clocks, then hi=raw.
4. ovr_i held high, rght_spd=0, for 4 periods -> ovr_shtdwn sets at the 4th period end +1 clock and all gates go low. ovr_i high only at cnt<128 -> no shutdown.
5. 3 periods with qual, 1 clean period, 3 more with qual -> no shutdown. clr_shtdwn pulsed at the set clock while shut down -> ovr_shtdwn=0.
6. rst_n asserted mid-period with hi=1 -> all gates 0 asynchronously. After release, cnt=0 and the duty shadows are at 0x400.

Source files
------------

// File: rtl/mtr_drv_pkg.sv
// Shared types and helpers for the dual H-bridge PWM driver.
package mtr_drv_pkg;

  localparam int PWM_W  = 11;
  localparam int DEAD_W = 8;
  localparam logic [PWM_W-1:0] DUTY_MID = 11'h400;
  localparam logic signed [11:0] SPD_MAX = 12'sh3FF;
  localparam logic signed [11:0] SPD_MIN = 12'shC00;

  typedef logic [PWM_W-1:0] duty_t;

  // Clamp to the 11-bit signed range, then offset so zero speed is 50% duty.
  function automatic duty_t spd2duty(input logic signed [11:0] spd);
    logic signed [11:0] sat;
    if (spd > SPD_MAX)
      sat = SPD_MAX;
    else if (spd < SPD_MIN)
      sat = SPD_MIN;
    else
      sat = spd;
    return duty_t'(sat + 12'sh400);
  endfunction

endpackage

// File: rtl/mtr_drv_pwm_nonoverlap.sv
// Complementary gate generation with dead time for one half-bridge pair.
module nonoverlap
  import mtr_drv_pkg::*;
#(
  parameter int DEAD_TIME = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic gate_en,
  output logic hi,
  output logic lo
);

  logic              raw_q;
  logic [DEAD_W-1:0] dead_q, dead_d;
  logic              trans, ready;

  // dead_q counts low clocks already spent since the last raw edge or gate release.
  assign trans = raw ^ raw_q;
  assign ready = gate_en & ~trans & (dead_q == DEAD_W'(DEAD_TIME));
  assign hi    = ready & raw;
  assign lo    = ready & ~raw;

  always_comb begin
    dead_d = dead_q;
    if (!gate_en)
      dead_d = '0;
    else if (trans)
      dead_d = DEAD_W'(1);
    else if (dead_q != DEAD_W'(DEAD_TIME))
      dead_d = dead_q + DEAD_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q  <= 1'b0;
      dead_q <= '0;
    end else begin
      raw_q  <= raw;
      dead_q <= dead_d;
    end
  end

endmodule

// File: rtl/mtr_drv_pwm.sv
// Dual-motor PWM driver: period counter, duty shadows, dead-time gates and
// over-current shutdown.
module mtr_drv_pwm
  import mtr_drv_pkg::*;
#(
  parameter int DEAD_TIME   = 32,
  parameter int BLANK_CNT   = 128,
  parameter int OVR_PERIODS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  input  logic        drv_en,
  input  logic        ovr_i,
  input  logic        clr_shtdwn,
  output logic        lft_hi,
  output logic        lft_lo,
  output logic        rght_hi,
  output logic        rght_lo,
  output logic        period_strt,
  output logic        ovr_shtdwn
);

  duty_t       cnt_q, cnt_d;
  duty_t       lft_duty_q, rght_duty_q;
  logic        period_strt_q;
  logic        shtdwn_q, flag_q;
  logic [3:0]  consec_q, consec_d;
  logic        period_end, gate_en, qual;

  assign cnt_d      = cnt_q + 11'd1;
  assign period_end = (cnt_q == 11'h7FF);
  assign gate_en    = drv_en & ~shtdwn_q;
  assign qual       = ovr_i & (lft_hi | rght_hi) & (cnt_q >= PWM_W'(BLANK_CNT));
  assign consec_d   = (consec_q == 4'hF) ? consec_q : consec_q + 4'd1;

  // Duty shadows only move on the last count so a period is never split.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      lft_duty_q    <= DUTY_MID;
      rght_duty_q   <= DUTY_MID;
      period_strt_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      period_strt_q <= period_end;
      if (period_end) begin
        lft_duty_q  <= spd2duty(lft_spd);
        rght_duty_q <= spd2duty(rght_spd);
      end
    end
  end

  // A clear request outranks a pending shutdown in the same clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shtdwn_q <= 1'b0;
      consec_q <= '0;
      flag_q   <= 1'b0;
    end else if (clr_shtdwn) begin
      shtdwn_q <= 1'b0;
      consec_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      if (consec_q >= 4'(OVR_PERIODS))
        shtdwn_q <= 1'b1;
      if (period_end) begin
        consec_q <= (flag_q | qual) ? consec_d : 4'd0;
        flag_q   <= 1'b0;
      end else if (qual) begin
        flag_q <= 1'b1;
      end
    end
  end

  nonoverlap #(.DEAD_TIME(DEAD_TIME)) u_lft (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw     (cnt_q < lft_duty_q),
    .gate_en (gate_en),
    .hi      (lft_hi),
    .lo      (lft_lo)
  );

  nonoverlap #(.DEAD_TIME(DEAD_TIME)) u_rght (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw     (cnt_q < rght_duty_q),
    .gate_en (gate_en),
    .hi      (rght_hi),
    .lo      (rght_lo)
  );

  assign period_strt = period_strt_q;
  assign ovr_shtdwn  = shtdwn_q;

endmodule
